rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Parametrised N-channel, WIDTH-bit registered multiplexer with built-in arbitration and valid/ready handshakes. It replaces fixed 2:1 select muxes wherever several producers compete for one sink, such as instruction-fetch and load/store requests sharing a memory port, or multiple writeback sources. It selects one requesting channel per cycle (round-robin or fixed priority) and registers the winner's data together with its channel index.

## Interface
- `WIDTH`, 32: data width per channel, ≥1.
- `N`, 4: number of input channels, ≥2; need not be a power of two.
- `MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `SELW`, clog2(N): width of the channel index. Derived; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  N  bit i: channel i presents data.
- `in_data`  in  N*WIDTH  channel i occupies slice [i*WIDTH +: WIDTH].
- `in_ready`  out  N  bit i: channel i's word is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered winner data.
- `out_sel`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  sink accepts the word this cycle.

## Operation
- Single-entry output register (`out_valid`, `out_data`, `out_sel`) and, in round-robin mode, a priority pointer `ptr` (SELW bits, range 0..N-1).
- `load = !out_valid || out_ready`. The register may take a new word only when `load` is 1.
- Grant, combinational, at most one-hot:
  - MODE 0: the first i with `in_valid[i]` = 1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - MODE 1: the lowest i with `in_valid[i]` = 1.
- `in_ready[i] = load && grant[i]`. A transfer occurs on channel i when `in_valid[i] && in_ready[i]`.
- On a transfer at a clock edge:
  - `out_data` ← channel i slice.
  - `out_sel` ← i.
  - `out_valid` ← 1.
  - MODE 0 only: `ptr` ← (i+1) mod N, wrapping at N-1 → 0 for non-power-of-two N.
- On `load` with no request: `out_valid` ← 0, `out_data`/`out_sel` hold their values, `ptr` holds.
- When `out_valid && !out_ready`:
  - `out_data`, `out_sel` and `out_valid` stay stable.
  - All `in_ready` = 0.
  - `ptr` holds.
- Simultaneous drain and fill (`out_valid && out_ready` with a request pending) gives back-to-back transfers with no bubble.
- `in_ready` depends combinationally on `in_valid`, `ptr`, `out_valid` and `out_ready`. Sources must not drive `in_valid` from `in_ready`.
- Once raised, a source holds `in_valid` and its data stable until accepted. The block does not check this.
- MODE 1 can starve high-index channels. This is intended.

## Timing
- Reset (`rst` = 1 at an edge):
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
  - While `rst` is high, `in_ready` = all 0.
  - Reset overrides any transfer in the same cycle: no word is captured.
- Reset mid-operation discards the held word. The sink sees `out_valid` = 0 from the cycle after the reset edge.
- Latency: a word accepted at edge k appears on `out_*` from edge k. It is visible in cycle k+1 and remains until the edge where `out_ready` = 1.
- Throughput: one word per cycle while `out_ready` = 1 continuously.
- Fairness (MODE 0): with all N channels requesting continuously, each channel is granted exactly once in any N consecutive transfers.
- No combinational path from `in_data` to `out_data`.

## Test plan
- **Reset:** assert `rst` 2 cycles with all `in_valid` = 1. Required: `out_valid` = 0, `out_sel` = 0, `out_data` = 0, `in_ready` = 0 throughout; first transfer after release goes to ch0.
- **Round-robin, N=4, WIDTH=32, MODE 0:** all channels valid with data 0xA0+i, `out_ready` = 1. Required: `out_sel` sequence 0,1,2,3,0,1, one per cycle, with `out_data` matching each index and no bubbles.
- **Wrap, non-power-of-two N=3:** only ch2 and ch0 valid. Required: grants alternate 0,2,0,2 and `ptr` wraps 2→0 with no out-of-range index.
- **Backpressure:** ch1 valid with 0xDEADBEEF, `out_ready` = 0 for 5 cycles, ch3 also raising `in_valid`. Required: `out_data` = 0xDEADBEEF and `out_sel` = 1 stable for all 5 cycles, `in_ready` = 0; on `out_ready` = 1, ch3 is accepted in the same cycle and appears next.
- **Fixed priority, MODE 1:** ch0 and ch2 valid continuously. Required: ch0 granted every cycle and ch2 never; after ch0 drops, ch2 is granted the next cycle.
- **Reset mid-stream:** assert `rst` while `out_valid` = 1, `out_ready` = 0. Required: `out_valid` = 0 the next cycle, the held word is never delivered, and `ptr` restarts at 0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// N-channel registered mux with round-robin or fixed-priority arbitration.
// A single output register carries the winning word and its channel index under valid/ready flow control.
module rr_mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             any_req;
    logic             load;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_next;

    // Search starts at ptr in round-robin mode and at 0 in fixed-priority mode.
    // The search index wraps at N so a non-power-of-two N never produces an out-of-range channel.
    always_comb begin : arbitrate
        int idx;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        any_req    = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (MODE == 0) ? int'(ptr) + k : k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && in_valid[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
                grant_data = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                if (MODE == 0) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: round-robin N=4, round-robin N=3 and fixed-priority N=4 instances.
// Expected words are queued as stimulus is driven and popped as the sink takes them.
module tb_rr_mux_arbiter;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // round-robin, N=4
    logic         rst4, ov4, ordy4;
    logic [3:0]   v4, r4;
    logic [127:0] d4;
    logic [31:0]  od4;
    logic [1:0]   os4;
    // round-robin, N=3
    logic         rst3, ov3, ordy3;
    logic [2:0]   v3, r3;
    logic [95:0]  d3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    // fixed priority, N=4
    logic         rstf, ovf, ordyf;
    logic [3:0]   vf, rf;
    logic [127:0] df;
    logic [31:0]  odf;
    logic [1:0]   osf;

    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(0)) u_rr4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_data(d4), .in_ready(r4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4));

    rr_mux_arbiter #(.WIDTH(32), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_data(d3), .in_ready(r3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3));

    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(1)) u_fp (
        .clk(clk), .rst(rstf), .in_valid(vf), .in_data(df), .in_ready(rf),
        .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(ordyf));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle reset of every instance; returns just after a falling edge with reset released.
    task automatic rst_all();
        @(negedge clk);
        rst4 = 1'b1; rst3 = 1'b1; rstf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0; rst3 = 1'b0; rstf = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst4 = 1'b1;
        v4 = 4'hF;
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + i;
        ordy4 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (ov4 !== 1'b0 || os4 !== 2'd0 || od4 !== 32'd0 || r4 !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_state: out_valid=%b out_sel=%0d out_data=%h in_ready=%b, required 0 0 00000000 0000",
                         ov4, os4, od4, r4);
            end
        end
        rst4 = 1'b0;
        sbq.push_back('{sel: 2'd0, data: 32'hA0});
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        e = sbq.pop_front();
        if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data) begin
            n_fail++;
            $display("FAIL reset_first_grant: valid=%b sel=%0d data=%h, required 1 %0d %h",
                     ov4, os4, od4, e.sel, e.data);
        end
        v4 = 4'h0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        v4 = 4'hF;
        ordy4 = 1'b1;
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + i;
        rst_all();
        for (int i = 0; i < 6; i++)
            sbq.push_back('{sel: 2'(i % 4), data: 32'hA0 + 32'(i % 4)});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: scoreboard empty", i);
            end else begin
                e = sbq.pop_front();
                if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data) begin
                    n_fail++;
                    $display("FAIL rr_seq[%0d]: valid=%b sel=%0d data=%h, required 1 %0d %h",
                             i, ov4, os4, od4, e.sel, e.data);
                end
            end
        end
        v4 = 4'h0;
    endtask

    task automatic test_wrap3();
        exp_t e;
        logic [1:0] exp_ptr;
        v3 = 3'b101;
        d3 = '0;
        d3[0 +: 32]  = 32'h30;
        d3[64 +: 32] = 32'h32;
        ordy3 = 1'b1;
        rst_all();
        for (int i = 0; i < 6; i++)
            sbq.push_back((i % 2 == 0) ? '{sel: 2'd0, data: 32'h30} : '{sel: 2'd2, data: 32'h32});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            exp_ptr = (e.sel == 2'd2) ? 2'd0 : e.sel + 2'd1;
            n_tests++;
            if (ov3 !== 1'b1 || os3 !== e.sel || od3 !== e.data) begin
                n_fail++;
                $display("FAIL wrap3_seq[%0d]: valid=%b sel=%0d data=%h, required 1 %0d %h",
                         i, ov3, os3, od3, e.sel, e.data);
            end
            n_tests++;
            if (u_rr3.ptr !== exp_ptr) begin
                n_fail++;
                $display("FAIL wrap3_ptr[%0d]: ptr=%0d, required %0d", i, u_rr3.ptr, exp_ptr);
            end
        end
        v3 = 3'b000;
    endtask

    task automatic test_backpressure();
        exp_t e;
        v4 = 4'h0;
        ordy4 = 1'b0;
        rst_all();
        v4 = 4'b0010;
        d4 = '0;
        d4[32 +: 32] = 32'hDEADBEEF;
        d4[96 +: 32] = 32'h33333333;
        sbq.push_back('{sel: 2'd1, data: 32'hDEADBEEF});
        sbq.push_back('{sel: 2'd3, data: 32'h33333333});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) v4 = 4'b1000;
            #1;
            e = sbq[0];
            n_tests++;
            if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data || r4 !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: valid=%b sel=%0d data=%h in_ready=%b, required 1 %0d %h 0000",
                         i, ov4, os4, od4, r4, e.sel, e.data);
            end
        end
        ordy4 = 1'b1;
        #1;
        n_tests++;
        if (r4 !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b, required 1000", r4);
        end
        void'(sbq.pop_front());
        @(posedge clk);
        @(negedge clk);
        v4 = 4'h0;
        e = sbq.pop_front();
        n_tests++;
        if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data) begin
            n_fail++;
            $display("FAIL bp_next: valid=%b sel=%0d data=%h, required 1 %0d %h",
                     ov4, os4, od4, e.sel, e.data);
        end
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        vf = 4'b0101;
        df = '0;
        df[0 +: 32]  = 32'hF0;
        df[64 +: 32] = 32'hF2;
        ordyf = 1'b1;
        rst_all();
        repeat (4) sbq.push_back('{sel: 2'd0, data: 32'hF0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            n_tests++;
            if (ovf !== 1'b1 || osf !== e.sel || odf !== e.data || rf !== 4'b0001) begin
                n_fail++;
                $display("FAIL fp_ch0[%0d]: valid=%b sel=%0d data=%h in_ready=%b, required 1 %0d %h 0001",
                         i, ovf, osf, odf, rf, e.sel, e.data);
            end
        end
        vf = 4'b0100;
        #1;
        n_tests++;
        if (rf !== 4'b0100) begin
            n_fail++;
            $display("FAIL fp_ch2_ready: in_ready=%b, required 0100", rf);
        end
        sbq.push_back('{sel: 2'd2, data: 32'hF2});
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (ovf !== 1'b1 || osf !== e.sel || odf !== e.data) begin
            n_fail++;
            $display("FAIL fp_ch2: valid=%b sel=%0d data=%h, required 1 %0d %h",
                     ovf, osf, odf, e.sel, e.data);
        end
        vf = 4'h0;
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        v4 = 4'b0100;
        d4 = '0;
        d4[64 +: 32] = 32'h22222222;
        ordy4 = 1'b0;
        rst_all();
        sbq.push_back('{sel: 2'd2, data: 32'h22222222});
        @(negedge clk);
        v4 = 4'h0;
        e = sbq[0];
        n_tests++;
        if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data) begin
            n_fail++;
            $display("FAIL mid_held: valid=%b sel=%0d data=%h, required 1 %0d %h",
                     ov4, os4, od4, e.sel, e.data);
        end
        rst4 = 1'b1;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (ov4 !== 1'b0 || u_rr4.ptr !== 2'd0 || r4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b ptr=%0d in_ready=%b, required 0 0 0000", ov4, u_rr4.ptr, r4);
        end
        rst4 = 1'b0;
        ordy4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (ov4 !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_deliver[%0d]: valid=%b sel=%0d data=%h, required valid 0", i, ov4, os4, od4);
            end
        end
        v4 = 4'hF;
        for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + i;
        sbq.push_back('{sel: 2'd0, data: 32'hA0});
        @(negedge clk);
        v4 = 4'h0;
        e = sbq.pop_front();
        n_tests++;
        if (ov4 !== 1'b1 || os4 !== e.sel || od4 !== e.data) begin
            n_fail++;
            $display("FAIL mid_restart: valid=%b sel=%0d data=%h, required 1 %0d %h",
                     ov4, os4, od4, e.sel, e.data);
        end
    endtask

    initial begin
        rst4 = 1'b1; rst3 = 1'b1; rstf = 1'b1;
        v4 = '0; v3 = '0; vf = '0;
        d4 = '0; d3 = '0; df = '0;
        ordy4 = 1'b0; ordy3 = 1'b0; ordyf = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap3();
        test_backpressure();
        test_fixed_priority();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
